// File: rtl/rv32_ahb_arbiter_pkg.sv
// rtl/rv32_ahb_arbiter_pkg.sv - shared types and AHB constants for the rv32 bus arbiter
package rv32_ahb_arbiter_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic [0:0] {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } bus_owner_e;

    // NONSEQ and SEQ both carry a real transfer; IDLE and BUSY do not.
    function automatic logic htrans_active(input logic [1:0] htrans);
        return htrans[1];
    endfunction

endpackage

// File: rtl/rv32_ahb_arbiter_if.sv
// rtl/rv32_ahb_arbiter_if.sv - one AHB-Lite request/response link (master or slave side)
interface rv32_ahb_arbiter_if;
    import rv32_ahb_arbiter_pkg::*;

    logic [XLEN-1:0] haddr;
    logic [1:0]      htrans;
    logic            hwrite;
    logic [2:0]      hsize;
    logic [XLEN-1:0] hwdata;
    logic            hready;
    logic            hresp;

    modport master (
        output haddr, htrans, hwrite, hsize, hwdata,
        input  hready, hresp
    );

    modport slave (
        input  haddr, htrans, hwrite, hsize, hwdata,
        output hready, hresp
    );

endinterface

// File: rtl/rv32_ahb_arbiter.sv
// rtl/rv32_ahb_arbiter.sv - two-master AHB-Lite arbiter, DMA priority with CPU hold limit
module rv32_ahb_arbiter
    import rv32_ahb_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 16
)
(
    input  logic               clk,
    input  logic               rst_n,
    rv32_ahb_arbiter_if.slave  m0,
    rv32_ahb_arbiter_if.slave  m1,
    input  logic               m1_req,
    output logic               m1_grant,
    output logic               cpu_hold,
    rv32_ahb_arbiter_if.master bus
);

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    bus_owner_e owner_q, owner_d;
    bus_owner_e data_owner_q, data_owner_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic       cpu_slot_q, cpu_slot_d;

    logic m0_active, m1_active, owner_active;

    assign m0_active    = htrans_active(m0.htrans);
    assign m1_active    = htrans_active(m1.htrans);
    assign owner_active = (owner_q == OWN_DMA) ? m1_active : m0_active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q      <= OWN_CPU;
            data_owner_q <= OWN_CPU;
            hold_cnt_q   <= '0;
            cpu_slot_q   <= 1'b0;
        end else begin
            owner_q      <= owner_d;
            data_owner_q <= data_owner_d;
            hold_cnt_q   <= hold_cnt_d;
            cpu_slot_q   <= cpu_slot_d;
        end
    end

    // Everything is frozen across slave wait states, including ERROR's first cycle.
    always_comb begin
        owner_d      = owner_q;
        data_owner_d = data_owner_q;
        hold_cnt_d   = hold_cnt_q;
        cpu_slot_d   = cpu_slot_q;
        if (bus.hready) begin
            if (owner_active) begin
                data_owner_d = owner_q;
            end
            case (owner_q)
                OWN_CPU: begin
                    cpu_slot_d = 1'b0;
                    if (m1_req && !cpu_slot_q) begin
                        owner_d    = OWN_DMA;
                        hold_cnt_d = '0;
                    end
                end
                OWN_DMA: begin
                    if (!m1_req) begin
                        owner_d = OWN_CPU;
                    end else if (m1_active) begin
                        if (hold_cnt_q == HOLD_LAST) begin
                            // Tenure exhausted: hand the CPU a guaranteed slot if it is waiting.
                            if (m0_active) begin
                                owner_d    = OWN_CPU;
                                cpu_slot_d = 1'b1;
                            end
                        end else begin
                            hold_cnt_d = hold_cnt_q + 8'd1;
                        end
                    end
                end
                default: owner_d = OWN_CPU;
            endcase
        end
    end

    always_comb begin
        if (owner_q == OWN_DMA) begin
            bus.haddr  = m1.haddr;
            bus.htrans = m1.htrans;
            bus.hwrite = m1.hwrite;
            bus.hsize  = m1.hsize;
        end else begin
            bus.haddr  = m0.haddr;
            bus.htrans = m0.htrans;
            bus.hwrite = m0.hwrite;
            bus.hsize  = m0.hsize;
        end
    end

    assign bus.hwdata = (data_owner_q == OWN_DMA) ? m1.hwdata : m0.hwdata;

    assign m0.hresp  = bus.hresp & (data_owner_q == OWN_CPU);
    assign m1.hresp  = bus.hresp & (data_owner_q == OWN_DMA);
    assign m0.hready = bus.hready & ((data_owner_q == OWN_CPU) || (owner_q == OWN_CPU));
    assign m1.hready = bus.hready & ((data_owner_q == OWN_DMA) || (owner_q == OWN_DMA));

    assign m1_grant = (owner_q == OWN_DMA);
    assign cpu_hold = (owner_q != OWN_CPU);

endmodule
